// File: rtl/uart_frame_pkg.sv
// =====================================================================
// Module   : uart_frame_pkg - shared state encoding and sync constants
// Revision : 1.0
// =====================================================================
`default_nettype none

package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] DEF_SYNC0 = 8'hA5;
  localparam logic [7:0] DEF_SYNC1 = 8'h5A;

endpackage

`default_nettype wire

// File: rtl/frame_idle_timer.sv
// =====================================================================
// Module   : frame_idle_timer - saturating idle counter, flags TIMEOUT_CYC
// Revision : 1.0
// =====================================================================
`default_nettype none

module frame_idle_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
// =====================================================================
// Module   : uart_frame_ctrl - sync-header hunt and double-buffered frame load
// Options  : UART_FRAME_TIMEOUT_EN adds an idle-timeout abort (frame_err)
// Revision : 1.0
// =====================================================================
`default_nettype none

module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         FRAME_LEN   = 30000,
  parameter int         ADDR_W      = 15,
  parameter logic [7:0] SYNC0       = DEF_SYNC0,
  parameter logic [7:0] SYNC1       = DEF_SYNC1,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_flag,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [7:0]        wr_data,
  output logic              buf_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  frame_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_flag),
    .run     ((state == SYNC) || (state == LOAD)),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      buf_sel    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_flag && (rx_data == SYNC0)) begin
            state <= SYNC;
            busy  <= 1'b1;
          end
        end
        SYNC: begin
          // A received byte always beats a coincident timeout
          if (rx_flag) begin
            if (rx_data == SYNC1) begin
              state <= LOAD;
              addr  <= '0;
            end else if (rx_data != SYNC0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            addr      <= '0;
            frame_err <= 1'b1;
          end
        end
        LOAD: begin
          if (rx_flag) begin
            wr_en   <= 1'b1;
            wr_data <= rx_data;
            wr_addr <= {~buf_sel, addr};
            if (addr == LAST_ADDR) begin
              state <= DONE;
            end else begin
              addr <= addr + 1'b1;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            addr      <= '0;
            frame_err <= 1'b1;
          end
        end
        DONE: begin
          // Last write has already landed; handing the buffer over is now safe
          frame_done <= 1'b1;
          buf_sel    <= ~buf_sel;
          addr       <= '0;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
// =====================================================================
// Module   : tb_uart_frame_ctrl - directed self-checking bench, FRAME_LEN=4
// Revision : 1.0
// =====================================================================
`default_nettype none

module tb_uart_frame_ctrl;

  localparam int FL = 4;
  localparam int AW = 15;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_flag = 1'b0;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [7:0]    wr_data;
  logic          buf_sel;
  logic          busy;
  logic          frame_done;
  logic          frame_err;

  uart_frame_ctrl #(
    .FRAME_LEN   (FL),
    .ADDR_W      (AW),
    .SYNC0       (8'hA5),
    .SYNC1       (8'h5A),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_flag    (rx_flag),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .buf_sel    (buf_sel),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [15:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  int          wq_cyc  [$];
  int          fd_cyc  [$];
  int          fe_cyc  [$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    if (frame_err === 1'b1) fe_cyc.push_back(cyc);
  end

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  seq [8];
  int          fedge [8];
  logic        exp_buf = 1'b0;

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    fd_cyc.delete(); fe_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // fedge[i] is the clock edge index at which byte i is sampled
  task automatic send_bytes(input int n, input bit b2b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_flag = 1'b1;
      rx_data = seq[i];
      fedge[i] = cyc + 1;
      if (!b2b) begin
        @(negedge clk);
        rx_flag = 1'b0;
      end
    end
    if (b2b) begin
      @(negedge clk);
      rx_flag = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (wr_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 0000", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    n_checks++; if (buf_sel !== 1'b0) begin n_fail++; $display("FAIL reset_buf_sel: got %b expected 0", buf_sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_nominal();
    clear_logs();
    seq = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    send_bytes(6, 1'b0);
    idle(3);
    n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL nominal_wr_count: got %0d expected 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      n_checks++; if (wq_addr[i] !== {~exp_buf, 15'(i)}) begin n_fail++; $display("FAIL nominal_addr[%0d]: got %h expected %h", i, wq_addr[i], {~exp_buf, 15'(i)}); end
      n_checks++; if (wq_data[i] !== seq[i+2]) begin n_fail++; $display("FAIL nominal_data[%0d]: got %h expected %h", i, wq_data[i], seq[i+2]); end
      n_checks++; if (wq_cyc[i] != fedge[i+2]) begin n_fail++; $display("FAIL nominal_wr_latency[%0d]: got %0d expected %0d", i, wq_cyc[i], fedge[i+2]); end
    end
    n_checks++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL nominal_done_count: got %0d expected 1", fd_cyc.size()); end
    else begin
      n_checks++; if (fd_cyc[0] != fedge[5] + 1) begin n_fail++; $display("FAIL nominal_done_time: got %0d expected %0d", fd_cyc[0], fedge[5] + 1); end
    end
    exp_buf = ~exp_buf;
    n_checks++; if (buf_sel !== 1'b1) begin n_fail++; $display("FAIL nominal_buf_sel: got %b expected 1", buf_sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nominal_busy: got %b expected 0", busy); end
  endtask

  task automatic test_second_frame();
    clear_logs();
    seq = '{8'hA5, 8'h5A, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00};
    send_bytes(6, 1'b0);
    idle(3);
    n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL second_wr_count: got %0d expected 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      n_checks++; if (wq_addr[i] !== {1'b0, 15'(i)}) begin n_fail++; $display("FAIL second_addr[%0d]: got %h expected %h", i, wq_addr[i], {1'b0, 15'(i)}); end
      n_checks++; if (wq_data[i] !== seq[i+2]) begin n_fail++; $display("FAIL second_data[%0d]: got %h expected %h", i, wq_data[i], seq[i+2]); end
    end
    n_checks++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL second_done_count: got %0d expected 1", fd_cyc.size()); end
    exp_buf = ~exp_buf;
    n_checks++; if (buf_sel !== 1'b0) begin n_fail++; $display("FAIL second_buf_sel: got %b expected 0", buf_sel); end
  endtask

  task automatic test_sync_recovery();
    clear_logs();
    seq = '{8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_bytes(7, 1'b0);
    idle(3);
    n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL resync_wr_count: got %0d expected 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      n_checks++; if (wq_addr[i] !== {1'b1, 15'(i)}) begin n_fail++; $display("FAIL resync_addr[%0d]: got %h expected %h", i, wq_addr[i], {1'b1, 15'(i)}); end
      n_checks++; if (wq_data[i] !== seq[i+3]) begin n_fail++; $display("FAIL resync_data[%0d]: got %h expected %h", i, wq_data[i], seq[i+3]); end
    end
    n_checks++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL resync_done_count: got %0d expected 1", fd_cyc.size()); end
    exp_buf = ~exp_buf;
    n_checks++; if (buf_sel !== 1'b1) begin n_fail++; $display("FAIL resync_buf_sel: got %b expected 1", buf_sel); end

    clear_logs();
    seq = '{8'hA5, 8'h00, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_bytes(7, 1'b0);
    idle(3);
    n_checks++; if (wq_addr.size() != 0) begin n_fail++; $display("FAIL broken_hdr_wr_count: got %0d expected 0", wq_addr.size()); end
    n_checks++; if (fd_cyc.size() != 0) begin n_fail++; $display("FAIL broken_hdr_done_count: got %0d expected 0", fd_cyc.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL broken_hdr_busy: got %b expected 0", busy); end
    n_checks++; if (buf_sel !== 1'b1) begin n_fail++; $display("FAIL broken_hdr_buf_sel: got %b expected 1", buf_sel); end
  endtask

  task automatic test_reset_mid_load();
    clear_logs();
    seq = '{8'hA5, 8'h5A, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(4, 1'b0);
    n_checks++; if (wq_addr.size() != 2) begin n_fail++; $display("FAIL midload_wr_count: got %0d expected 2", wq_addr.size()); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midload_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (buf_sel !== 1'b0) begin n_fail++; $display("FAIL midload_buf_sel: got %b expected 0", buf_sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midload_busy: got %b expected 0", busy); end
    n_checks++; if (wr_addr !== 16'h0000) begin n_fail++; $display("FAIL midload_wr_addr: got %h expected 0000", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL midload_wr_data: got %h expected 00", wr_data); end
    n_checks++; if ({wr_en, frame_done, frame_err} !== 3'b000) begin n_fail++; $display("FAIL midload_pulses: got %b expected 000", {wr_en, frame_done, frame_err}); end
    idle(2);
    rst_n = 1'b1;
    exp_buf = 1'b0;
    idle(2);
    clear_logs();
    seq = '{8'hA5, 8'h5A, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h00, 8'h00};
    send_bytes(6, 1'b0);
    idle(3);
    n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL after_reset_wr_count: got %0d expected 4", wq_addr.size()); end
    else begin
      n_checks++; if (wq_addr[0] !== 16'h8000) begin n_fail++; $display("FAIL after_reset_first_addr: got %h expected 8000", wq_addr[0]); end
    end
    exp_buf = ~exp_buf;
    n_checks++; if (buf_sel !== 1'b1) begin n_fail++; $display("FAIL after_reset_buf_sel: got %b expected 1", buf_sel); end
  endtask

  task automatic test_timeout();
    int last;
    clear_logs();
    seq = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(4, 1'b0);
    last = fedge[3];
    idle(30);
`ifdef UART_FRAME_TIMEOUT_EN
    n_checks++; if (fe_cyc.size() != 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 1", fe_cyc.size()); end
    else begin
      n_checks++; if (fe_cyc[0] != last + TO + 1) begin n_fail++; $display("FAIL timeout_err_time: got %0d expected %0d", fe_cyc[0], last + TO + 1); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    n_checks++; if (buf_sel !== exp_buf) begin n_fail++; $display("FAIL timeout_buf_sel: got %b expected %b", buf_sel, exp_buf); end
    n_checks++; if (fd_cyc.size() != 0) begin n_fail++; $display("FAIL timeout_done_count: got %0d expected 0", fd_cyc.size()); end
    clear_logs();
    seq = '{8'hA5, 8'h5A, 8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00};
    send_bytes(6, 1'b0);
    idle(3);
    n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL post_timeout_wr_count: got %0d expected 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      n_checks++; if (wq_addr[i] !== {~exp_buf, 15'(i)}) begin n_fail++; $display("FAIL post_timeout_addr[%0d]: got %h expected %h", i, wq_addr[i], {~exp_buf, 15'(i)}); end
    end
`else
    n_checks++; if (fe_cyc.size() != 0) begin n_fail++; $display("FAIL no_timeout_err_count: got %0d expected 0", fe_cyc.size()); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL no_timeout_busy: got %b expected 1", busy); end
    seq = '{8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(2, 1'b0);
    idle(3);
    n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL no_timeout_wr_count: got %0d expected 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      n_checks++; if (wq_addr[i] !== {~exp_buf, 15'(i)}) begin n_fail++; $display("FAIL no_timeout_addr[%0d]: got %h expected %h", i, wq_addr[i], {~exp_buf, 15'(i)}); end
    end
`endif
    n_checks++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL timeout_frame_done: got %0d expected 1", fd_cyc.size()); end
    exp_buf = ~exp_buf;
    n_checks++; if (buf_sel !== exp_buf) begin n_fail++; $display("FAIL timeout_final_buf_sel: got %b expected %b", buf_sel, exp_buf); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    // Seventh byte arrives while the controller sits in DONE and must be dropped
    seq = '{8'hA5, 8'h5A, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hA5, 8'h00};
    send_bytes(7, 1'b1);
    idle(3);
    n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected 4", wq_addr.size()); end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      n_checks++; if (wq_addr[i] !== {~exp_buf, 15'(i)}) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, wq_addr[i], {~exp_buf, 15'(i)}); end
      n_checks++; if (wq_data[i] !== seq[i+2]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wq_data[i], seq[i+2]); end
      n_checks++; if (wq_cyc[i] != fedge[2] + i) begin n_fail++; $display("FAIL b2b_wr_cycle[%0d]: got %0d expected %0d", i, wq_cyc[i], fedge[2] + i); end
    end
    n_checks++; if (fd_cyc.size() != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", fd_cyc.size()); end
    else begin
      n_checks++; if (fd_cyc[0] != fedge[5] + 1) begin n_fail++; $display("FAIL b2b_done_time: got %0d expected %0d", fd_cyc[0], fedge[5] + 1); end
    end
    exp_buf = ~exp_buf;
    n_checks++; if (buf_sel !== exp_buf) begin n_fail++; $display("FAIL b2b_buf_sel: got %b expected %b", buf_sel, exp_buf); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_byte_ignored: busy got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_second_frame();
    test_sync_recovery();
    test_reset_mid_load();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Sequences the byte stream from the UART receiver into a double-buffered frame RAM. It hunts for a two-byte sync header, then writes exactly FRAME_LEN payload bytes to the back buffer. On completion it swaps buffers and pulses `frame_done`. It sits between the UART receiver (`rx_data`/`rx_flag`) and the dual-port image RAM whose read side feeds the display.

## Interface
- `FRAME_LEN`, 30000: payload bytes per frame; 2 ≤ FRAME_LEN ≤ 2^ADDR_W.
- `ADDR_W`, 15: per-buffer address width.
- `SYNC0`, 8'hA5: first header byte.
- `SYNC1`, 8'h5A: second header byte.
- `TIMEOUT_CYC`, 50000: idle clocks before an in-progress frame is aborted (used only with the macro).
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte, valid while `rx_flag`=1.
- `rx_flag` in 1: one-cycle strobe per received byte.
- `wr_en` out 1: RAM write strobe.
- `wr_addr` out ADDR_W+1: {buffer bit, byte address}.
- `wr_data` out 8: RAM write data.
- `buf_sel` out 1: buffer currently owned by the reader. Writes always go to `~buf_sel`.
- `busy` out 1: high in SYNC, LOAD and DONE.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- Reset values: state IDLE; `addr`=0; `wr_en`=0, `wr_addr`=0, `wr_data`=0, `buf_sel`=0, `busy`=0, `frame_done`=0, `frame_err`=0.
- **IDLE:** on `rx_flag` with `rx_data`==SYNC0, go to SYNC. All other bytes are discarded.
- **SYNC:** on `rx_flag`:
  - `rx_data`==SYNC1: go to LOAD with `addr`=0.
  - `rx_data`==SYNC0: stay in SYNC (handles a repeated A5).
  - Any other byte: go to IDLE.
- **LOAD:** on each `rx_flag`, register `wr_en`=1, `wr_data`=`rx_data`, `wr_addr`={~buf_sel, addr}.
  - If `addr`==FRAME_LEN-1: go to DONE.
  - Otherwise: `addr`+1.
  - Sync values inside the payload are ordinary data.
- **DONE:** lasts one cycle. Pulse `frame_done`, toggle `buf_sel`, clear `addr`, go to IDLE.
- `addr` is ADDR_W bits and never exceeds FRAME_LEN-1. There is no modular wrap inside a frame.
- Reset mid-frame: everything returns to reset values. The partial frame is discarded and `buf_sel` returns to 0.

## Timing
- `rx_flag` at cycle t gives `wr_en`/`wr_addr`/`wr_data` at t+1, for exactly one cycle.
- Last payload byte: `rx_flag` at t, its `wr_en` at t+1, state DONE at t+1. At t+2, `frame_done`=1 and `buf_sel` has toggled.
- The reader may switch buffers on the `buf_sel` edge. The last write lands one cycle before the toggle.
- Back-to-back `rx_flag` on consecutive cycles must be accepted. The UART spacing is ≥155 clocks, but the bench stresses spacing of 1.
- `rx_flag` arriving in DONE is ignored. The sender always sends a new header first.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYC+1)`-bit idle counter runs in SYNC and LOAD and clears on every `rx_flag`.
  - When it reaches TIMEOUT_CYC: pulse `frame_err`, clear `addr`, go to IDLE. `buf_sel` does not change.
  - If `rx_flag` coincides with the timeout, `rx_flag` wins and the counter clears.
- Not defined: no counter is built, `frame_err` is tied to 0, and the controller waits indefinitely.

## Structure
- `uart_frame_pkg` holds:
  - State enum: IDLE, SYNC, LOAD, DONE (2 bits).
  - Default SYNC0/SYNC1 constants.
- Sub-module `frame_idle_timer` holds the timeout counter (inputs: `clear`, `run`; output: `expired`). It is instantiated only under the macro.

## Test plan
(FRAME_LEN=4, TIMEOUT_CYC=20 for simulation.)
- **Nominal frame.** Send A5 5A 11 22 33 44. Expect:
  - Four `wr_en` pulses at `wr_addr` 0x8000..0x8003 with data 11 22 33 44.
  - `frame_done` two cycles after byte 44's flag; `buf_sel` goes 0→1.
- **Second frame.** Send the same header plus 55 66 77 88. Expect writes to 0x0000..0x0003 and `buf_sel` going 1→0.
- **Sync recovery.**
  - Send A5 A5 5A 01 02 03 04: a frame is accepted.
  - Send A5 00 5A 01 02 03 04: no `wr_en` and no `frame_done`.
- **Timeout (macro on).** Send A5 5A 11 22, then idle 20 cycles. Expect:
  - A `frame_err` pulse, state IDLE, `buf_sel` unchanged.
  - A following full frame still writes from address 0.
- **Reset mid-LOAD.** Assert `rst_n`=0 after two payload bytes. Expect all outputs at reset values and `buf_sel`=0.
- **Back-to-back flags.** Send six `rx_flag` strobes on consecutive cycles. Expect four consecutive `wr_en` cycles and a correct `frame_done`.
